// File: rtl/alu_shift_pkg.sv
// rtl/alu_shift_pkg.sv - shared types and helpers for the iterative left-shift block
package alu_shift_pkg;

  typedef enum logic [1:0] {
    SHL  = 2'b00,
    ROL  = 2'b01,
    RCL  = 2'b10,
    SHLD = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

  function automatic int amt_width(input int word_width);
    return $clog2(word_width);
  endfunction

endpackage

// File: rtl/left_shift_stage.sv
// rtl/left_shift_stage.sv - applies up to STEP_BITS chained 1-bit left-shift steps
module left_shift_stage
  import alu_shift_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int STEP_BITS  = 1,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  carry,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic [WORD_WIDTH-1:0] fill,
  input  shift_op_e             op,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  next_carry,
  output logic [WORD_WIDTH-1:0] next_word,
  output logic [WORD_WIDTH-1:0] next_fill
);

  logic fill_bit;

  always_comb begin
    next_carry = carry;
    next_word  = word;
    next_fill  = fill;
    fill_bit   = 1'b0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (CNT_WIDTH'(i) < count) begin
        // fill bit must be chosen from the pre-step carry/word/fill
        unique case (op)
          SHL:     fill_bit = 1'b0;
          ROL:     fill_bit = next_word[WORD_WIDTH-1];
          RCL:     fill_bit = next_carry;
          default: fill_bit = next_fill[WORD_WIDTH-1];
        endcase
        next_carry = next_word[WORD_WIDTH-1];
        next_word  = {next_word[WORD_WIDTH-2:0], fill_bit};
        next_fill  = next_fill << 1;
      end
    end
  end

endmodule

// File: rtl/iterative_shift_block.sv
// rtl/iterative_shift_block.sv - multi-cycle left-shift ALU block with valid/ready handshake
module iterative_shift_block
  import alu_shift_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int STEP_BITS  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            op_i,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  input  logic [WORD_WIDTH-1:0] c_i,
  input  logic                  cf_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] r_o,
  output logic                  cf_o,
  output logic                  zf_o,
  output logic                  of_o,
  output logic                  pf_o,
  output logic                  sf_o
);

  localparam int AW = amt_width(WORD_WIDTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] STEP = CW'(STEP_BITS);

  shift_state_e          state;
  shift_op_e             op;
  logic                  carry;
  logic                  a_msb;
  logic [WORD_WIDTH-1:0] word;
  logic [WORD_WIDTH-1:0] fill;
  logic [CW-1:0]         rem;
  logic [CW-1:0]         step_cnt;
  logic                  next_carry;
  logic [WORD_WIDTH-1:0] next_word;
  logic [WORD_WIDTH-1:0] next_fill;
  logic [AW-1:0]         amount;
  logic                  accept;
  logic                  unused_b;

  assign amount   = b_i[AW-1:0];
  assign unused_b = ^b_i[WORD_WIDTH-1:AW];
  assign ready_o  = (state == IDLE) | ((state == DONE) & ready_i);
  assign valid_o  = (state == DONE);
  assign accept   = valid_i & ready_o;
  assign step_cnt = (rem < STEP) ? rem : STEP;

  left_shift_stage #(
    .WORD_WIDTH(WORD_WIDTH),
    .STEP_BITS (STEP_BITS),
    .CNT_WIDTH (CW)
  ) u_stage (
    .carry     (carry),
    .word      (word),
    .fill      (fill),
    .op        (op),
    .count     (step_cnt),
    .next_carry(next_carry),
    .next_word (next_word),
    .next_fill (next_fill)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      op    <= SHL;
      carry <= 1'b0;
      a_msb <= 1'b0;
      word  <= '0;
      fill  <= '0;
      rem   <= '0;
      r_o   <= '0;
      cf_o  <= 1'b0;
      zf_o  <= 1'b0;
      of_o  <= 1'b0;
      pf_o  <= 1'b0;
      sf_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            carry <= cf_i;
            word  <= a_i;
            fill  <= c_i;
            a_msb <= a_i[WORD_WIDTH-1];
            rem   <= {1'b0, amount};
            op    <= shift_op_e'(op_i);
            if (amount == '0) begin
              // zero-length shift: result is the operand, sign unchanged so no overflow
              state <= DONE;
              r_o   <= a_i;
              cf_o  <= cf_i;
              zf_o  <= ~|a_i;
              pf_o  <= a_i[0];
              sf_o  <= a_i[WORD_WIDTH-1];
              of_o  <= 1'b0;
            end else begin
              state <= SHIFT;
            end
          end else if (state == DONE && ready_i) begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          carry <= next_carry;
          word  <= next_word;
          fill  <= next_fill;
          rem   <= rem - step_cnt;
          if (rem <= STEP) begin
            state <= DONE;
            r_o   <= next_word;
            cf_o  <= next_carry;
            zf_o  <= ~|next_word;
            pf_o  <= next_word[0];
            sf_o  <= next_word[WORD_WIDTH-1];
            of_o  <= next_word[WORD_WIDTH-1] ^ a_msb;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
